// File: rtl/pci_bus_arbiter.sv
// Four-master PCI bus arbiter with round-robin selection, bus parking,
// a one-cycle idle gap between different grantees, and grant timeout.
module pci_bus_arbiter #(
    parameter int PARK_MASTER = 0,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       r,
    input  logic [3:0] req_n,
    input  logic       frame,
    input  logic       irdy,
    output logic [3:0] gnt_n,
    output logic [1:0] owner,
    output logic       bus_busy,
    output logic       timeout_pulse
);

    typedef enum logic [1:0] {PARK, GRANT, BUSY, GAP} state_e;

    localparam logic [1:0] PARK_IDX = 2'(PARK_MASTER);
    localparam logic [4:0] TO_LAST  = 5'(GNT_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_owner_q, last_owner_d;
    logic [1:0] next_owner_q, next_owner_d;
    logic       park_q, park_d;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] gnt_n_q, gnt_n_d;
    logic       bus_busy_q, bus_busy_d;
    logic       timeout_q, timeout_d;
    logic       rearb;
    logic [2:0] park_pick, rb_pick;

    // Returns {found, index}; search order is last+1, last+2, last+3, last.
    function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] rq_n);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (!rq_n[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        park_pick    = rr_pick(last_owner_q, req_n);
        rb_pick      = rr_pick(owner_q, req_n);
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        next_owner_d = next_owner_q;
        park_d       = park_q;
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
        rearb        = 1'b0;

        case (state_q)
            PARK: begin
                if (park_pick[2]) begin
                    if (park_pick[1:0] == owner_q) begin
                        state_d = GRANT;
                        cnt_d   = '0;
                    end else begin
                        state_d      = GAP;
                        next_owner_d = park_pick[1:0];
                    end
                end else begin
                    owner_d = PARK_IDX;
                end
            end
            GAP: begin
                if (park_q) begin
                    state_d = PARK;
                    owner_d = PARK_IDX;
                    park_d  = 1'b0;
                end else begin
                    state_d = GRANT;
                    owner_d = next_owner_q;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                // A started transaction wins over withdrawal and timeout.
                if (!frame) begin
                    state_d = BUSY;
                end else if (req_n[owner_q]) begin
                    rearb = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    rearb     = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            BUSY: begin
                if (frame && irdy) rearb = 1'b1;
            end
            default: state_d = PARK;
        endcase

        // Searching from the owner just served puts that owner last in line.
        if (rearb) begin
            last_owner_d = owner_q;
            if (rb_pick[2]) begin
                if (rb_pick[1:0] == owner_q) begin
                    state_d = GRANT;
                    cnt_d   = '0;
                end else begin
                    state_d      = GAP;
                    next_owner_d = rb_pick[1:0];
                end
            end else if (owner_q == PARK_IDX) begin
                state_d = PARK;
            end else begin
                state_d = GAP;
                park_d  = 1'b1;
            end
        end

        gnt_n_d    = (state_d == GAP) ? 4'b1111 : ~(4'b0001 << owner_d);
        bus_busy_d = (state_d == BUSY);
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q      <= PARK;
            owner_q      <= PARK_IDX;
            last_owner_q <= 2'd3;
            next_owner_q <= 2'd0;
            park_q       <= 1'b0;
            cnt_q        <= '0;
            gnt_n_q      <= 4'b1111;
            bus_busy_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            next_owner_q <= next_owner_d;
            park_q       <= park_d;
            cnt_q        <= cnt_d;
            gnt_n_q      <= gnt_n_d;
            bus_busy_q   <= bus_busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign gnt_n         = gnt_n_q;
    assign owner         = owner_q;
    assign bus_busy      = bus_busy_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-level reference
// model of the arbiter rules.
module tb_pci_bus_arbiter;
    localparam int PM = 0;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       r = 1'b1;
    logic [3:0] req_n = 4'hF;
    logic       frame = 1'b1;
    logic       irdy = 1'b1;
    logic [3:0] gnt_n;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout_pulse;

    pci_bus_arbiter #(.PARK_MASTER(PM), .GNT_TIMEOUT(TO)) dut (
        .clk(clk), .r(r), .req_n(req_n), .frame(frame), .irdy(irdy),
        .gnt_n(gnt_n), .owner(owner), .bus_busy(bus_busy), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 parked, 1 granted idle, 2 transfer, 3 gap
    int m_mode = 0, m_own = PM, m_last = 3, m_next = 0, m_park = 0, m_cnt = 0;
    logic [3:0] m_gnt = 4'hF;
    logic       m_busy = 1'b0, m_to = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int last, input logic [3:0] rq);
        for (int k = 1; k <= 4; k++)
            if (rq[(last + k) % 4] == 1'b0) return (last + k) % 4;
        return -1;
    endfunction

    task automatic handover();
        int w;
        w = pick(m_own, req_n);
        m_last = m_own;
        if (w == m_own) begin m_mode = 1; m_cnt = 0; end
        else if (w >= 0) begin m_mode = 3; m_next = w; end
        else if (m_own == PM) m_mode = 0;
        else begin m_mode = 3; m_park = 1; end
    endtask

    task automatic model_step();
        int w;
        m_to = 1'b0;
        if (r) begin
            m_mode = 0; m_own = PM; m_last = 3; m_next = 0; m_park = 0; m_cnt = 0;
            m_gnt = 4'hF; m_busy = 1'b0;
            return;
        end
        if (m_mode == 0) begin
            w = pick(m_last, req_n);
            if (w < 0) m_own = PM;
            else if (w == m_own) begin m_mode = 1; m_cnt = 0; end
            else begin m_mode = 3; m_next = w; end
        end else if (m_mode == 3) begin
            if (m_park != 0) begin m_mode = 0; m_own = PM; m_park = 0; end
            else begin m_mode = 1; m_own = m_next; m_cnt = 0; end
        end else if (m_mode == 1) begin
            if (!frame) m_mode = 2;
            else if (req_n[m_own]) handover();
            else if (m_cnt == TO - 1) begin m_to = 1'b1; handover(); end
            else m_cnt++;
        end else if (frame && irdy) begin
            handover();
        end
        m_gnt  = (m_mode == 3) ? 4'hF : 4'hF ^ (4'(1) << m_own);
        m_busy = (m_mode == 2);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("gnt_n", gnt_n, m_gnt);
        chk("owner", owner, m_own);
        chk("bus_busy", bus_busy, m_busy);
        chk("timeout_pulse", timeout_pulse, m_to);
        chk("one_grant", $countones(~gnt_n) <= 1, 1);
    endtask

    initial begin
        int n, nf, nb;
        int order[$];
        logic [3:0] prev_gnt;
        logic prev_busy, saw_to;

        // Reset and park
        r = 1'b1; tick(); tick();
        chk("rst_gnt", gnt_n, 4'b1111);
        chk("rst_busy", bus_busy, 0);
        chk("rst_owner", owner, PM);
        r = 1'b0; tick();
        chk("park_gnt", gnt_n, 4'b1110);
        tick();
        chk("park_owner", owner, 0);

        // Single transfer by master 2 with a stretched last data phase
        req_n = 4'b1011; tick();
        chk("st_gap", gnt_n, 4'b1111);
        tick();
        chk("st_grant", gnt_n, 4'b1011);
        frame = 1'b0; tick();
        chk("st_busy", bus_busy, 1);
        frame = 1'b1; irdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ldp_busy", bus_busy, 1);
            chk("ldp_gnt", gnt_n, 4'b1011);
        end
        irdy = 1'b1; req_n = 4'hF; tick();
        chk("st_exit_gap", gnt_n, 4'b1111);
        chk("st_exit_busy", bus_busy, 0);
        tick();
        chk("st_repark", gnt_n, 4'b1110);

        // Reset in the middle of a transfer by master 3
        req_n = 4'b0111; tick(); tick();
        chk("mb_grant", gnt_n, 4'b0111);
        frame = 1'b0; tick();
        chk("mb_busy", bus_busy, 1);
        r = 1'b1; tick();
        chk("mb_rst_gnt", gnt_n, 4'b1111);
        chk("mb_rst_busy", bus_busy, 0);
        chk("mb_rst_owner", owner, PM);
        r = 1'b0; frame = 1'b1; req_n = 4'hF; tick();
        chk("mb_post_gnt", gnt_n, 4'b1110);

        // Round robin with all masters requesting and one-cycle transfers
        r = 1'b1; tick(); r = 1'b0;
        req_n = 4'b0000; irdy = 1'b1;
        prev_gnt = gnt_n; prev_busy = bus_busy; nf = 0;
        for (int i = 0; i < 60 && order.size() < 5; i++) begin
            frame = (m_mode == 1) ? 1'b0 : 1'b1;
            tick();
            if (bus_busy && !prev_busy) order.push_back(int'(owner));
            if (gnt_n == 4'hF) nf++;
            if (gnt_n == 4'hF && prev_gnt == 4'hF) chk("rr_single_gap", 1, 0);
            prev_gnt = gnt_n; prev_busy = bus_busy;
        end
        chk("rr_count", order.size(), 5);
        for (int i = 0; i < order.size() && i < 5; i++) chk("rr_order", order[i], i % 4);
        chk("rr_gaps", nf, 4);
        frame = 1'b1; req_n = 4'hF; tick(); tick(); tick();

        // Timeout: master 1 holds its grant idle, master 3 waiting
        r = 1'b1; tick(); r = 1'b0;
        req_n = 4'b0101; frame = 1'b1;
        n = 0; saw_to = 1'b0;
        for (int i = 0; i < 40 && !saw_to; i++) begin
            tick();
            if (gnt_n[1] == 1'b0) n++;
            if (timeout_pulse) begin
                saw_to = 1'b1;
                chk("to_revoked", gnt_n[1], 1);
            end
        end
        chk("to_seen", saw_to, 1);
        chk("to_cycles", n, 16);
        tick();
        chk("to_pulse_len", timeout_pulse, 0);
        chk("to_next", gnt_n, 4'b0111);
        req_n = 4'hF; tick(); tick();
        chk("to_repark", gnt_n, 4'b1110);

        // Randomized traffic against the model
        nb = 0;
        for (int i = 0; i < 600; i++) begin
            r     = ($urandom_range(0, 63) == 0);
            req_n = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            frame = ($urandom_range(0, 3) != 0);
            irdy  = ($urandom_range(0, 2) != 0);
            tick();
            if (bus_busy) nb++;
        end
        chk("rand_busy_seen", nb > 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pci_bus_arbiter.md
PCI_BUS_ARBITER -- requirements
Module: pci_bus_arbiter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter: PARK_MASTER, 0, index (0-3) of the master granted when no request is pending.
REQ-003 Parameter: GNT_TIMEOUT, 16, cycles a granted master may leave frame high before its grant is revoked (range 2-31).
REQ-004 clk  input  1  bus clock.
REQ-005 r  input  1  reset; synchronous, active-high.
REQ-006 req_n  input  4  per-master bus request; active-low.
REQ-007 frame  input  1  PCI FRAME#; active-low.
REQ-008 irdy  input  1  PCI IRDY#; active-low.
REQ-009 gnt_n  output  4  per-master bus grant; active-low; registered.
REQ-010 owner  output  2  index of the current or parked grantee; registered.
REQ-011 bus_busy  output  1  high while state is BUSY; registered.
REQ-012 timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout; registered.

Function
REQ-013 The state machine SHALL have four states: PARK, GRANT, BUSY and GAP.
REQ-014 In PARK, GRANT and BUSY, gnt_n SHALL equal ~(1<<owner); in GAP, gnt_n SHALL be 4'b1111.
REQ-015 No more than one gnt_n bit SHALL be low in any cycle.
REQ-016 Winner selection SHALL be round-robin: search starts at last_owner+1 mod 4 and selects the first index with req_n low.
REQ-017 last_owner SHALL be updated to owner whenever GRANT or BUSY is exited.
REQ-018 PARK, any req_n low: if the winner equals owner, go to GRANT; otherwise latch the winner into next_owner and go to GAP.
REQ-019 PARK, no request: stay in PARK with owner=PARK_MASTER.
REQ-020 GAP SHALL last exactly one cycle. Exit to GRANT with owner=next_owner, or to PARK with owner=PARK_MASTER when the park flag is set.
REQ-021 GRANT, frame sampled low: go to BUSY. This SHALL take priority over timeout and withdrawal in the same cycle.
REQ-022 GRANT, frame high and req_n[owner] high: the master has withdrawn; rearbitrate per REQ-024 without a timeout_pulse.
REQ-023 GRANT, frame high and timeout counter == GNT_TIMEOUT-1: rearbitrate per REQ-024 and assert timeout_pulse for one cycle.
REQ-024 Rearbitration: choose a winner per REQ-016 using the owner just served as last_owner.
REQ-025 On rearbitration with a winner equal to owner, go to GRANT directly and clear the counter.
REQ-026 On rearbitration with a different winner, go to GAP with that winner in next_owner.
REQ-027 On rearbitration with no request: go to PARK directly if owner == PARK_MASTER; otherwise go to GAP with the park flag set.
REQ-028 The timeout counter SHALL be 5 bits, cleared on every entry to GRANT, and SHALL increment each GRANT cycle while frame is high.
REQ-029 BUSY: hold the grant and ignore req_n changes until the bus is idle (frame==1 and irdy==1), then rearbitrate per REQ-024.
REQ-030 BUSY SHALL not exit while frame==1 and irdy==0, because the last data phase is still in progress.
REQ-031 A master whose grant is revoked SHALL be searched last in the next arbitration.

Reset
REQ-032 While r==1 at a clock edge, the block SHALL load state=PARK, owner=PARK_MASTER, last_owner=3, next_owner=0, park flag=0, counter=0, gnt_n=4'b1111, bus_busy=0 and timeout_pulse=0.
REQ-033 On the first edge with r==0, gnt_n SHALL be decoded from the state entered on that edge.
REQ-034 Reset asserted mid-transaction SHALL release all grants at that edge, regardless of frame or irdy.

Verification
REQ-035 Park: with r pulsed and then req_n=4'b1111 held, gnt_n=4'b1110 from the first post-reset edge onward, owner=0, bus_busy=0.
REQ-036 Single transfer: req_n[2]=0 from PARK gives gnt_n 1111 (GAP) then 1011; frame=0 gives bus_busy=1 on the next edge; after frame=1 and irdy=1, req released gives GAP then park at 1110.
REQ-037 Round-robin: req_n=4'b0000 held with 1-cycle transactions gives grant order 0,1,2,3,0, each handover separated by exactly one all-high cycle.
REQ-038 Timeout: req_n[1]=0 with frame held high gives gnt_n[1] low for exactly 16 cycles, then timeout_pulse=1 for one cycle, and the grant moves to another requester or park.
REQ-039 Last data phase: frame=1 and irdy=0 for 3 cycles keeps bus_busy=1 and the grant unchanged; the exit edge follows irdy=1.
REQ-040 Reset mid-BUSY: r=1 with frame=0 gives gnt_n=1111, bus_busy=0 and owner=PARK_MASTER at that edge.
